// File: rtl/updown_mod_ctr.sv
// Parametrised up/down modulo counter: load, enable, wrap/saturate mode,
// registered terminal-count pulse and sticky overflow flag.
module updown_mod_ctr #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             evt_s;

  // Next-state: load beats enable; boundaries use explicit compares so
  // non-power-of-two moduli wrap correctly.
  always_comb begin
    cnt_d = cnt_q;
    evt_s = 1'b0;
    if (load) begin
      if (load_val > MAX_VAL) begin
        cnt_d = MAX_VAL;
      end else begin
        cnt_d = load_val;
      end
    end else if (en) begin
      if (up_dn) begin
        if (cnt_q == MAX_VAL) begin
          evt_s = 1'b1;
          cnt_d = sat ? MAX_VAL : CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        if (cnt_q == CNT_ZERO) begin
          evt_s = 1'b1;
          cnt_d = sat ? CNT_ZERO : MAX_VAL;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
    tc_d = evt_s;
    // A boundary event in the same cycle as a clear keeps the flag set.
    if (evt_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= RESET_VAL;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_mod_ctr.sv
// Bench for updown_mod_ctr: a modulo-10 instance (WIDTH=4, MAX_VAL=9) and a
// full-range 8-bit instance, checked with directed sequences and a model.
module tb_updown_mod_ctr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, MAX_VAL=9
  logic       a_rst, a_en, a_up, a_sat, a_load, a_clr;
  logic [3:0] a_lv, a_cnt;
  logic       a_tc, a_ovf;
  // Instance B: WIDTH=8, default MAX_VAL=255
  logic       b_rst, b_en, b_up, b_sat, b_load, b_clr;
  logic [7:0] b_lv, b_cnt;
  logic       b_tc, b_ovf;

  updown_mod_ctr #(.WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'd0)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up_dn(a_up), .sat(a_sat),
    .load(a_load), .load_val(a_lv), .clr_ovf(a_clr),
    .cnt(a_cnt), .tc(a_tc), .ovf(a_ovf));

  updown_mod_ctr #(.WIDTH(8)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up_dn(b_up), .sat(b_sat),
    .load(b_load), .load_val(b_lv), .clr_ovf(b_clr),
    .cnt(b_cnt), .tc(b_tc), .ovf(b_ovf));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int ma_cnt, mb_cnt;
  bit ma_tc, ma_ovf, mb_tc, mb_ovf;

  task automatic model_step(input int maxv, input bit r, input bit l, input bit e,
                            input bit u, input bit s, input bit c, input int lv,
                            inout int mc, inout bit mt, inout bit mo);
    bit evt;
    evt = 1'b0;
    if (!r) begin
      mc = 0; mt = 1'b0; mo = 1'b0;
    end else if (l) begin
      mc = (lv > maxv) ? maxv : lv;
      mt = 1'b0;
      mo = mo && !c;
    end else if (e) begin
      if (u) begin
        evt = (mc == maxv);
        mc  = (evt && s) ? mc : (mc + 1) % (maxv + 1);
      end else begin
        evt = (mc == 0);
        mc  = (evt && s) ? mc : (mc + maxv) % (maxv + 1);
      end
      mt = evt;
      mo = evt || (mo && !c);
    end else begin
      mt = 1'b0;
      mo = mo && !c;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(9, a_rst, a_load, a_en, a_up, a_sat, a_clr, int'(a_lv), ma_cnt, ma_tc, ma_ovf);
    model_step(255, b_rst, b_load, b_en, b_up, b_sat, b_clr, int'(b_lv), mb_cnt, mb_tc, mb_ovf);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b0; a_en = 1'b1; a_load = 1'b1; a_lv = 4'd5;
    b_rst = 1'b0; b_en = 1'b1; b_load = 1'b1; b_lv = 8'd7;
    step();
    step();
    n_checks++;
    if ({a_cnt, a_tc, a_ovf} !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_a: got cnt=%0d tc=%0b ovf=%0b want 0 0 0", a_cnt, a_tc, a_ovf);
    end
    n_checks++;
    if ({b_cnt, b_tc, b_ovf} !== {8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_b: got cnt=%0d tc=%0b ovf=%0b want 0 0 0", b_cnt, b_tc, b_ovf);
    end
    a_load = 1'b0; b_load = 1'b0; b_en = 1'b0; b_rst = 1'b1;
  endtask

  task automatic test_up_wrap();
    a_rst = 1'b1; a_en = 1'b1; a_up = 1'b1; a_sat = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_checks++;
      if ({a_cnt, a_tc, a_ovf} !== {4'(k % 10), 1'(k == 10), 1'(k >= 10)}) begin
        n_fail++;
        $display("FAIL up_wrap[%0d]: got cnt=%0d tc=%0b ovf=%0b want %0d %0b %0b",
                 k, a_cnt, a_tc, a_ovf, k % 10, k == 10, k >= 10);
      end
    end
  endtask

  task automatic test_down_wrap_sat();
    logic [3:0] exp_c [0:7];
    logic       exp_t [0:7];
    exp_c = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd1, 4'd0, 4'd0, 4'd0};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      a_load = (k == 0 || k == 4);
      a_lv   = (k == 0) ? 4'd2 : 4'd1;
      a_en   = !a_load;
      a_up   = 1'b0;
      a_sat  = (k >= 4);
      step();
      n_checks++;
      if ({a_cnt, a_tc, a_ovf} !== {exp_c[k], exp_t[k], 1'b1}) begin
        n_fail++;
        $display("FAIL down[%0d]: got cnt=%0d tc=%0b ovf=%0b want %0d %0b 1",
                 k, a_cnt, a_tc, a_ovf, exp_c[k], exp_t[k]);
      end
    end
    a_load = 1'b0; a_sat = 1'b0;
  endtask

  task automatic test_load();
    a_load = 1'b1; a_en = 1'b1; a_up = 1'b1; a_lv = 4'd5;
    step();
    n_checks++;
    if ({a_cnt, a_tc} !== {4'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL load_prio: got cnt=%0d tc=%0b want 5 0", a_cnt, a_tc);
    end
    a_lv = 4'd15;
    step();
    n_checks++;
    if ({a_cnt, a_tc, a_ovf} !== {4'd9, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL load_clamp: got cnt=%0d tc=%0b ovf=%0b want 9 0 1", a_cnt, a_tc, a_ovf);
    end
    a_load = 1'b0;
  endtask

  task automatic test_ovf_race();
    a_en = 1'b0; a_clr = 1'b1;
    step();
    n_checks++;
    if ({a_cnt, a_tc, a_ovf} !== {4'd9, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_clear: got cnt=%0d tc=%0b ovf=%0b want 9 0 0", a_cnt, a_tc, a_ovf);
    end
    a_en = 1'b1; a_up = 1'b1; a_sat = 1'b0;
    step();
    n_checks++;
    if ({a_cnt, a_tc, a_ovf} !== {4'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_race: got cnt=%0d tc=%0b ovf=%0b want 0 1 1", a_cnt, a_tc, a_ovf);
    end
    a_clr = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [3:0] exp_c [0:5];
    logic       en_seq [0:5];
    exp_c  = '{4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd7};
    en_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      a_load = (k == 0); a_lv = 4'd3; a_en = en_seq[k]; a_up = 1'b1;
      step();
      n_checks++;
      if ({a_cnt, a_tc} !== {exp_c[k], 1'b0}) begin
        n_fail++;
        $display("FAIL enable[%0d]: got cnt=%0d tc=%0b want %0d 0", k, a_cnt, a_tc, exp_c[k]);
      end
    end
    a_rst = 1'b0; a_load = 1'b1; a_lv = 4'd5; a_en = 1'b1;
    step();
    n_checks++;
    if ({a_cnt, a_tc, a_ovf} !== {4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got cnt=%0d tc=%0b ovf=%0b want 0 0 0", a_cnt, a_tc, a_ovf);
    end
    a_rst = 1'b1; a_load = 1'b0; a_en = 1'b0;
  endtask

  task automatic test_full_range();
    logic [7:0] exp_c [0:3];
    logic       exp_t [0:3];
    exp_c = '{8'd254, 8'd255, 8'd0, 8'd255};
    exp_t = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      b_load = (k == 0); b_lv = 8'd254; b_en = (k != 0);
      b_up = (k < 3); b_sat = 1'b0; b_clr = 1'b0;
      step();
      n_checks++;
      if ({b_cnt, b_tc, b_ovf} !== {exp_c[k], exp_t[k], 1'(k >= 2)}) begin
        n_fail++;
        $display("FAIL full_range[%0d]: got cnt=%0d tc=%0b ovf=%0b want %0d %0b %0b",
                 k, b_cnt, b_tc, b_ovf, exp_c[k], exp_t[k], k >= 2);
      end
    end
    b_load = 1'b0; b_en = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      a_rst  = ($urandom_range(0, 49) != 0);
      a_load = ($urandom_range(0, 7) == 0);
      a_en   = ($urandom_range(0, 3) != 0);
      a_up   = 1'($urandom);
      a_sat  = ($urandom_range(0, 3) == 0);
      a_clr  = ($urandom_range(0, 5) == 0);
      a_lv   = 4'($urandom);
      b_rst  = ($urandom_range(0, 49) != 0);
      b_load = ($urandom_range(0, 15) == 0);
      b_en   = ($urandom_range(0, 3) != 0);
      b_up   = ($urandom_range(0, 4) != 0);
      b_sat  = ($urandom_range(0, 3) == 0);
      b_clr  = ($urandom_range(0, 5) == 0);
      b_lv   = ($urandom_range(0, 1) == 0) ? 8'd253 : 8'($urandom);
      step();
      n_checks++;
      if ({a_cnt, a_tc, a_ovf} !== {4'(ma_cnt), ma_tc, ma_ovf}) begin
        n_fail++;
        $display("FAIL rand_a[%0d]: got cnt=%0d tc=%0b ovf=%0b want %0d %0b %0b",
                 k, a_cnt, a_tc, a_ovf, ma_cnt, ma_tc, ma_ovf);
      end
      n_checks++;
      if ({b_cnt, b_tc, b_ovf} !== {8'(mb_cnt), mb_tc, mb_ovf}) begin
        n_fail++;
        $display("FAIL rand_b[%0d]: got cnt=%0d tc=%0b ovf=%0b want %0d %0b %0b",
                 k, b_cnt, b_tc, b_ovf, mb_cnt, mb_tc, mb_ovf);
      end
    end
  endtask

  initial begin
    a_rst = 1'b0; a_en = 1'b0; a_up = 1'b1; a_sat = 1'b0; a_load = 1'b0; a_clr = 1'b0; a_lv = 4'd0;
    b_rst = 1'b0; b_en = 1'b0; b_up = 1'b1; b_sat = 1'b0; b_load = 1'b0; b_clr = 1'b0; b_lv = 8'd0;
    ma_cnt = 0; ma_tc = 1'b0; ma_ovf = 1'b0;
    mb_cnt = 0; mb_tc = 1'b0; mb_ovf = 1'b0;
    #1;
    test_reset();
    test_up_wrap();
    test_down_wrap_sat();
    test_load();
    test_ovf_race();
    test_mid_reset();
    test_full_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
